sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Two-requester arbiter in front of SDRAM_Controller. Shares its single read port (rd_startTrig/RD_ADR/RD_DATA/rd_busyFlag) and write port (wt_startTrig/WT_ADR/WT_DATA/wt_busyFlag) between requester 0 and requester 1.
- Round-robin grant, one SDRAM access in flight at a time.
- Drives the controller's start pulses and tracks its busy flags to completion.
- Returns ack, with read data for reads, to the granted requester.

Parameters:
- ADR_W, 24, address width; matches RD_ADR/WT_ADR.
- DATA_W, 16, data width; matches RD_DATA/WT_DATA.
- START_TIMEOUT, 8, maximum cycles to wait for the selected busy flag to rise after a start pulse.

Ports:
- global_CLK  in  1  single clock, shared with SDRAM_Controller.
- global_RST  in  1  asynchronous, active-high reset.
- p0_req  in  1  requester 0 request; level, held until p0_ack.
- p0_we  in  1  requester 0 operation: 1 = write, 0 = read.
- p0_adr  in  ADR_W  requester 0 address.
- p0_wdata  in  DATA_W  requester 0 write data.
- p0_ack  out  1  one-cycle pulse when requester 0's access completes.
- p0_rdata  out  DATA_W  requester 0 read data; valid while p0_ack=1 for a read, held afterwards.
- p1_req, p1_we, p1_adr, p1_wdata, p1_ack, p1_rdata  same as p0_* for requester 1.
- rd_startTrig  out  1  to controller: read start pulse.
- RD_ADR  out  ADR_W  to controller: read address.
- RD_DATA  in  DATA_W  from controller: read data.
- rd_busyFlag  in  1  from controller: read in progress.
- wt_startTrig  out  1  to controller: write start pulse.
- WT_ADR  out  ADR_W  to controller: write address.
- WT_DATA  out  DATA_W  to controller: write data.
- wt_busyFlag  in  1  from controller: write in progress.
- timeout_err  out  1  sticky; set when a busy flag fails to rise within START_TIMEOUT.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant=1 (requester 0 wins the first tie).
- Reset is asynchronous: asserting it mid-access returns to IDLE at once, drops start pulses and suppresses ack. Any in-flight controller access is abandoned.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK.
- IDLE:
  - Only p0_req set -> grant 0. Only p1_req set -> grant 1.
  - Both set -> grant the requester not equal to last_grant.
  - On grant: latch grant id, we, adr and wdata into internal registers; update last_grant; go to ISSUE.
  - Requester inputs changing after grant are ignored.
- ISSUE (exactly 1 cycle):
  - Assert rd_startTrig (we=0) or wt_startTrig (we=1) for one cycle.
  - RD_ADR/WT_ADR/WT_DATA are driven from the latched registers. They are valid from this cycle and held stable until ACK ends.
  - Clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - Selected busy=1 -> WAIT_DONE.
  - Else increment the counter. When the counter reaches START_TIMEOUT, set timeout_err and go to ACK, with rdata unchanged.
- WAIT_DONE:
  - Stay while selected busy=1.
  - On the first cycle busy=0: for a read, capture RD_DATA into the granted requester's pN_rdata register; go to ACK.
- ACK (1 cycle): pulse the granted requester's pN_ack; go to IDLE.
  - The requester must drop req in the cycle after ack, or it issues a new request.
  - A requester that keeps req high is granted again only after the other's pending request is served, if any.
- The unselected busy flag is ignored throughout.
- Latency with no contention and a controller that raises busy one cycle after the start pulse:
  - req sampled in IDLE at cycle 0, trig at cycle 1, busy seen at cycle 2.
  - ack arrives 2 cycles after busy falls: capture cycle, then ACK cycle.
- Minimum gap between back-to-back accesses: one IDLE cycle.
- Simultaneous new requests during an access: not sampled until IDLE. No queueing beyond the level-held req.
- Only the clear path for timeout_err is global_RST.
- pN_rdata of the non-granted requester is never modified.

Test Plan:
- Single read: p0_req=1, we=0, adr=0x000123; controller model returns 0xBEEF after 5 busy cycles -> one rd_startTrig pulse with RD_ADR=0x000123; p0_ack pulses once with p0_rdata=0xBEEF; p1_ack stays 0.
- Single write: p1_req=1, we=1, adr=0xABCDEF, wdata=0x1234 -> one wt_startTrig pulse; WT_ADR=0xABCDEF and WT_DATA=0x1234 stable through completion; p1_ack pulses once; no rd_startTrig.
- Tie and round-robin: both req held high for 4 accesses from reset -> grant order 0,1,0,1; exactly 4 start pulses, each separated by at least one idle cycle.
- Input change after grant: p0_adr changes 0x10->0x20 during WAIT_DONE -> controller address stays 0x10 until ack.
- Timeout: busy never rises -> timeout_err=1 exactly START_TIMEOUT=8 cycles after WAIT_BUSY entry; requester acked; the next access completes normally with timeout_err still 1.
- Reset mid-access: assert global_RST during WAIT_DONE -> all outputs 0 immediately, no ack; after release, both-req tie grants requester 0.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin arbiter sharing one SDRAM controller's read and write
// ports between two requesters, with one access in flight at a time.
module sdram_port_arbiter #(
    parameter int ADR_W         = 24,
    parameter int DATA_W        = 16,
    parameter int START_TIMEOUT = 8
) (
    input  logic              global_CLK,
    input  logic              global_RST,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADR_W-1:0]  p0_adr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADR_W-1:0]  p1_adr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              rd_startTrig,
    output logic [ADR_W-1:0]  RD_ADR,
    input  logic [DATA_W-1:0] RD_DATA,
    input  logic              rd_busyFlag,
    output logic              wt_startTrig,
    output logic [ADR_W-1:0]  WT_ADR,
    output logic [DATA_W-1:0] WT_DATA,
    input  logic              wt_busyFlag,
    output logic              timeout_err
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK} state_t;
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    state_t            state, state_nx;
    logic              gnt, last_grant, we_q;
    logic [ADR_W-1:0]  adr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic              busy, take, take_id, tmo, capture;

    // only the busy flag of the port actually in use is looked at
    assign busy    = we_q ? wt_busyFlag : rd_busyFlag;
    assign take    = p0_req | p1_req;
    assign take_id = (p0_req & p1_req) ? ~last_grant : ~p0_req;
    assign cnt_inc = cnt + CNT_W'(1);
    assign tmo     = (state == WAIT_BUSY) && !busy && (cnt_inc == CNT_W'(START_TIMEOUT));
    assign capture = (state == WAIT_DONE) && !busy && !we_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = take ? ISSUE : IDLE;
            ISSUE:     state_nx = WAIT_BUSY;
            WAIT_BUSY: state_nx = busy ? WAIT_DONE : tmo ? ACK : WAIT_BUSY;
            WAIT_DONE: state_nx = busy ? WAIT_DONE : ACK;
            ACK:       state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge global_CLK or posedge global_RST) begin
        if (global_RST) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            gnt         <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && take) begin
                gnt        <= take_id;
                last_grant <= take_id;
                we_q       <= take_id ? p1_we : p0_we;
                adr_q      <= take_id ? p1_adr : p0_adr;
                wdata_q    <= take_id ? p1_wdata : p0_wdata;
            end
            cnt <= (state == WAIT_BUSY) ? cnt_inc : '0;
            if (tmo) timeout_err <= 1'b1;
            if (capture && !gnt) p0_rdata <= RD_DATA;
            if (capture && gnt) p1_rdata <= RD_DATA;
        end
    end

    assign rd_startTrig = (state == ISSUE) && !we_q;
    assign wt_startTrig = (state == ISSUE) && we_q;
    assign RD_ADR       = adr_q;
    assign WT_ADR       = adr_q;
    assign WT_DATA      = wdata_q;
    assign p0_ack       = (state == ACK) && !gnt;
    assign p1_ack       = (state == ACK) && gnt;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed vectors, multi-cycle corner sequences and a random
// two-requester run against a controller model and a memory/fairness reference.
module tb_sdram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [23:0] p0_adr, p1_adr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [15:0] p0_rdata, p1_rdata;
    logic        rd_startTrig, wt_startTrig, timeout_err;
    logic [23:0] RD_ADR, WT_ADR;
    logic [15:0] WT_DATA;
    logic [15:0] RD_DATA = '0;
    logic        rd_busyFlag, wt_busyFlag;
    logic [100:0] all_outs;

    int total = 0;
    int bad = 0;
    int blen = 1;
    bit stall = 1'b0;
    logic [15:0] ref_mem [256];
    logic [15:0] exp_rd [2];

    typedef struct {
        bit          id;
        bit          we;
        logic [23:0] adr;
        logic [15:0] wd;
        int          blen;
        logic [15:0] exp_rdata;
        int          exp_lat;
    } vec_t;
    vec_t vecs [6];

    sdram_port_arbiter dut (
        .global_CLK(clk), .global_RST(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_adr(p0_adr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_adr(p1_adr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .rd_startTrig(rd_startTrig), .RD_ADR(RD_ADR), .RD_DATA(RD_DATA), .rd_busyFlag(rd_busyFlag),
        .wt_startTrig(wt_startTrig), .WT_ADR(WT_ADR), .WT_DATA(WT_DATA), .wt_busyFlag(wt_busyFlag),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    assign all_outs = {p0_ack, p1_ack, p0_rdata, p1_rdata, rd_startTrig, wt_startTrig,
                       RD_ADR, WT_ADR, WT_DATA, timeout_err};

    // controller model: busy rises the cycle after a start pulse, stays high blen cycles
    logic [15:0] ctl_mem [256];
    bit          inited = 1'b0;
    int          busy_cnt;
    logic [7:0]  c_adr;
    logic        c_we;
    logic [15:0] c_wd;
    always @(posedge clk or posedge rst) begin
        if (!inited) begin
            for (int i = 0; i < 256; i++) ctl_mem[i] <= 16'(i * 257);
            ctl_mem[8'h23] <= 16'hBEEF;
            inited <= 1'b1;
        end
        if (rst) begin
            rd_busyFlag <= 1'b0;
            wt_busyFlag <= 1'b0;
            busy_cnt    <= 0;
        end else if ((rd_startTrig || wt_startTrig) && !stall) begin
            c_we        <= wt_startTrig;
            c_adr       <= wt_startTrig ? WT_ADR[7:0] : RD_ADR[7:0];
            c_wd        <= WT_DATA;
            busy_cnt    <= (blen != 0) ? blen : int'($urandom_range(1, 6));
            rd_busyFlag <= rd_startTrig;
            wt_busyFlag <= wt_startTrig;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt    <= 0;
            rd_busyFlag <= 1'b0;
            wt_busyFlag <= 1'b0;
            if (c_we) ctl_mem[c_adr] <= c_wd;
            else RD_DATA <= ctl_mem[c_adr];
        end
    end

    // monitor sampled just after each rising edge
    int          rd_trigs = 0, wt_trigs = 0, gap_viol = 0;
    int          ack_cnt [2] = '{0, 0};
    bit          prev_act = 1'b0;
    logic        tr_we = 1'b0;
    logic [23:0] tr_adr = '0;
    logic [15:0] tr_wd = '0;
    always begin
        @(posedge clk);
        #1;
        if (rd_startTrig || wt_startTrig) begin
            if (prev_act) gap_viol++;
            if (rd_startTrig) rd_trigs++;
            if (wt_startTrig) wt_trigs++;
            tr_we  = wt_startTrig;
            tr_adr = wt_startTrig ? WT_ADR : RD_ADR;
            tr_wd  = WT_DATA;
        end
        if (p0_ack) ack_cnt[0]++;
        if (p1_ack) ack_cnt[1]++;
        prev_act = rd_startTrig || wt_startTrig || p0_ack || p1_ack;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit id, input bit req, input bit we, input logic [23:0] adr,
                         input logic [15:0] wd);
        if (id) begin
            p1_req = req; p1_we = we; p1_adr = adr; p1_wdata = wd;
        end else begin
            p0_req = req; p0_we = we; p0_adr = adr; p0_wdata = wd;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_rd = '{16'h0, 16'h0};
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic single(input vec_t v);
        int r0, w0, a0, a1, lat;
        bit seen, unstable;
        r0 = rd_trigs; w0 = wt_trigs; a0 = ack_cnt[0]; a1 = ack_cnt[1];
        blen = v.blen;
        @(negedge clk);
        drive(v.id, 1'b1, v.we, v.adr, v.wd);
        lat = 0; seen = 1'b0; unstable = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 3) drive(v.id, 1'b1, ~v.we, v.adr + 24'h10, ~v.wd);
            if (v.we ? (WT_ADR !== v.adr || WT_DATA !== v.wd) : (RD_ADR !== v.adr)) unstable = 1'b1;
            seen = v.id ? p1_ack : p0_ack;
        end
        drive(v.id, 1'b0, v.we, v.adr, v.wd);
        chk("single_latency", lat, v.exp_lat);
        if (v.we) ref_mem[v.adr[7:0]] = v.wd;
        else exp_rd[v.id] = v.exp_rdata;
        chk("single_rdata", {p0_rdata, p1_rdata}, {exp_rd[0], exp_rd[1]});
        repeat (2) @(negedge clk);
        chk("single_trigs", {rd_trigs - r0, wt_trigs - w0}, {v.we ? 32'd0 : 32'd1, v.we ? 32'd1 : 32'd0});
        chk("single_acks", {ack_cnt[0] - a0, ack_cnt[1] - a1}, {v.id ? 32'd0 : 32'd1, v.id ? 32'd1 : 32'd0});
        chk("single_addr_stable", unstable, 1'b0);
    endtask

    task automatic run_random(input int n_acks);
        bit          pend [2] = '{1'b0, 1'b0};
        bit          we_r [2];
        logic [23:0] adr_r [2];
        logic [15:0] wd_r [2];
        int          expect_next = -1;
        int          served = 0;
        int          cyc = 0;
        bit          a;
        blen = 0;
        while (served < n_acks && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                a = (i == 1) ? p1_ack : p0_ack;
                if (a) begin
                    chk("rnd_spurious_ack", pend[i], 1'b1);
                    if (expect_next != -1) chk("rnd_order", i, expect_next);
                    chk("rnd_issue", {tr_we, tr_adr, tr_we ? tr_wd : 16'h0},
                        {we_r[i], adr_r[i], we_r[i] ? wd_r[i] : 16'h0});
                    if (we_r[i]) ref_mem[adr_r[i][7:0]] = wd_r[i];
                    else exp_rd[i] = ref_mem[adr_r[i][7:0]];
                    chk("rnd_rdata", {p0_rdata, p1_rdata}, {exp_rd[0], exp_rd[1]});
                    pend[i] = 1'b0;
                    served++;
                    expect_next = pend[1-i] ? 1 - i : -1;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]  = 1'b1;
                    we_r[i]  = 1'($urandom_range(0, 1));
                    adr_r[i] = 24'($urandom);
                    wd_r[i]  = 16'($urandom);
                end
                drive(1'(i), pend[i], we_r[i], adr_r[i], wd_r[i]);
            end
        end
        chk("rnd_served", served, n_acks);
        drive(1'b0, 1'b0, 1'b0, 24'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 24'h0, 16'h0);
    endtask

    initial begin
        int k, t0, g0, a1;
        logic [3:0] ord;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 24'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 24'h0, 16'h0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 257);
        ref_mem[8'h23] = 16'hBEEF;
        exp_rd = '{16'h0, 16'h0};
        vecs[0] = '{1'b0, 1'b0, 24'h000123, 16'h0000, 5, 16'hBEEF, 8};
        vecs[1] = '{1'b1, 1'b1, 24'hABCDEF, 16'h1234, 3, 16'h0000, 6};
        vecs[2] = '{1'b0, 1'b0, 24'hABCDEF, 16'h0000, 1, 16'h1234, 4};
        vecs[3] = '{1'b0, 1'b1, 24'h000010, 16'h5555, 2, 16'h0000, 5};
        vecs[4] = '{1'b1, 1'b0, 24'h000010, 16'h0000, 4, 16'h5555, 7};
        vecs[5] = '{1'b1, 1'b0, 24'h000077, 16'h0000, 2, 16'h7777, 5};
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) single(vecs[i]);

        // both requesters held high from reset: strict alternation starting with 0
        do_reset();
        blen = 1; t0 = rd_trigs; g0 = gap_viol; ord = '0; k = 0;
        drive(1'b0, 1'b1, 1'b0, 24'h000001, 16'h0);
        drive(1'b1, 1'b1, 1'b0, 24'h000002, 16'h0);
        for (int n = 0; n < 4 && k < 200; ) begin
            @(negedge clk);
            k++;
            if (p0_ack || p1_ack) begin
                ord = {ord[2:0], p1_ack};
                n++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 24'h000001, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 24'h000002, 16'h0);
        repeat (3) @(negedge clk);
        chk("rr_order", ord, 4'b0101);
        chk("rr_trigs", rd_trigs - t0, 4);
        chk("rr_gap", gap_viol - g0, 0);
        exp_rd[0] = ref_mem[1];
        exp_rd[1] = ref_mem[2];
        chk("rr_rdata", {p0_rdata, p1_rdata}, {exp_rd[0], exp_rd[1]});

        // busy never rises
        stall = 1'b1;
        chk("to_pre", timeout_err, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 24'h000055, 16'h0);
        k = 0;
        while (!rd_startTrig && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("to_trig", rd_startTrig, 1'b1);
        k = 0;
        while (!timeout_err && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("to_delay", k, 9);
        chk("to_ack", {p0_ack, p1_ack}, 2'b10);
        chk("to_rdata", {p0_rdata, p1_rdata}, {exp_rd[0], exp_rd[1]});
        drive(1'b0, 1'b0, 1'b0, 24'h000055, 16'h0);
        stall = 1'b0;
        single('{1'b0, 1'b0, 24'h000077, 16'h0000, 2, 16'h7777, 5});
        chk("to_sticky", timeout_err, 1'b1);

        // asynchronous reset in the middle of a long read
        blen = 10;
        drive(1'b1, 1'b1, 1'b0, 24'h000033, 16'h0);
        k = 0;
        while (!rd_startTrig && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        a1 = ack_cnt[1];
        #1 rst = 1'b1;
        #1 chk("rst_outputs", all_outs, '0);
        exp_rd = '{16'h0, 16'h0};
        drive(1'b0, 1'b1, 1'b0, 24'h000001, 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        blen = 1;
        k = 0;
        while (!(p0_ack || p1_ack) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rst_first_grant", {p0_ack, p1_ack}, 2'b10);
        drive(1'b0, 1'b0, 1'b0, 24'h000001, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 24'h000033, 16'h0);
        exp_rd[0] = ref_mem[1];
        chk("rst_rdata", {p0_rdata, p1_rdata}, {exp_rd[0], exp_rd[1]});
        repeat (2) @(negedge clk);
        chk("rst_no_p1_ack", ack_cnt[1] - a1, 0);

        run_random(60);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
